// File: rtl/audio_pkg.sv
// Shared definitions for the audio record/playback path: sequencer states,
// default widths/timings and the per-state output decode.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    WAKE   = 2'd2,
    PLAY   = 2'd3
  } seq_state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int WAKE_CYCLES_DEF = 1024;

  typedef struct packed {
    logic busy;
    logic mic_en;
    logic amp_sd;
    logic amp_en;
  } mode_t;

  // Static pin levels for a state; registered alongside the state itself.
  function automatic mode_t mode_of(seq_state_e s);
    mode_t m;
    m.busy   = (s != IDLE);
    m.mic_en = (s == RECORD);
    m.amp_sd = (s == WAKE) || (s == PLAY);
    m.amp_en = (s == PLAY);
    return m;
  endfunction

endpackage

// File: rtl/audio_seq_ctrl_wake_timer.sv
// Loadable saturating down-counter; done while the count sits at zero.
// A load makes done rise exactly CYCLES cycles later.
module wake_timer
  import audio_pkg::*;
#(
  parameter int CYCLES = WAKE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)           cnt <= '0;
    else if (load)        cnt <= LOAD_VAL;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/audio_seq_ctrl.sv
// Record/playback sequencer: paces FIFO writes from the mic and reads to the
// PWM stage on divider ticks, and sequences amplifier power-up before playback.
module audio_seq_ctrl
  import audio_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_SAMPLES = 65535,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             rec_req,
  input  logic             play_req,
  input  logic             stop_req,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             mic_en,
  output logic             amp_en,
  output logic             amp_sd,
  output logic             busy,
  output logic [1:0]       state_led,
  output logic [CNT_W-1:0] rec_len,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

  seq_state_e       st;
  mode_t            mode;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             wake_load, wake_done;

  assign cnt_inc   = cnt + 1'b1;
  assign wake_load = (st == IDLE) && !rec_req && play_req &&
                     (rec_len != '0) && !fifo_empty;

  wake_timer #(.CYCLES(WAKE_CYCLES)) u_wake (
    .clk   (clk),
    .reset (reset),
    .load  (wake_load),
    .done  (wake_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= IDLE;
      mode     <= '0;
      cnt      <= '0;
      rec_len  <= '0;
      overflow <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      fifo_rd <= 1'b0;
      case (st)
        IDLE: begin
          if (rec_req) begin
            st       <= RECORD;
            mode     <= mode_of(RECORD);
            cnt      <= '0;
            overflow <= 1'b0;
          end else if (wake_load) begin
            st   <= WAKE;
            mode <= mode_of(WAKE);
            cnt  <= '0;
          end
        end
        RECORD: begin
          // stop wins over a coincident tick, so a full FIFO only flags overflow without stop
          if (stop_req || (tick && fifo_full)) begin
            st      <= IDLE;
            mode    <= mode_of(IDLE);
            rec_len <= cnt;
            if (!stop_req) overflow <= 1'b1;
          end else if (tick) begin
            fifo_wr <= 1'b1;
            cnt     <= cnt_inc;
            if (cnt_inc == MAX_CNT) begin
              st      <= IDLE;
              mode    <= mode_of(IDLE);
              rec_len <= cnt_inc;
            end
          end
        end
        WAKE: begin
          if (stop_req) begin
            st   <= IDLE;
            mode <= mode_of(IDLE);
          end else if (wake_done) begin
            st   <= PLAY;
            mode <= mode_of(PLAY);
          end
        end
        PLAY: begin
          if (stop_req || (tick && fifo_empty)) begin
            st   <= IDLE;
            mode <= mode_of(IDLE);
          end else if (tick) begin
            fifo_rd <= 1'b1;
            cnt     <= cnt_inc;
            if (cnt_inc == rec_len) begin
              st   <= IDLE;
              mode <= mode_of(IDLE);
            end
          end
        end
      endcase
    end
  end

  assign state_led = st;
  assign busy      = mode.busy;
  assign mic_en    = mode.mic_en;
  assign amp_sd    = mode.amp_sd;
  assign amp_en    = mode.amp_en;

endmodule
